// File: rtl/instr_fetcher.sv
// Fetch stage: looks up the PC in a small direct-mapped instruction cache and
// falls back to a valid/ready program-memory read on a miss.
module instr_fetcher #(
    parameter int PC_ADDR_WIDTH  = 8,
    parameter int INST_MSG_WIDTH = 16,
    parameter int CACHE_ENTRIES  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                cu_state,
    input  logic [PC_ADDR_WIDTH-1:0]  pc,
    input  logic                      flush,
    output logic                      mem_read_valid,
    output logic [PC_ADDR_WIDTH-1:0]  mem_read_addr,
    input  logic                      mem_read_ready,
    input  logic [INST_MSG_WIDTH-1:0] mem_read_data,
    output logic [1:0]                fetcher_state,
    output logic [INST_MSG_WIDTH-1:0] instr,
    output logic                      cache_hit
);

    localparam int IDX_W = $clog2(CACHE_ENTRIES);
    localparam int TAG_W = PC_ADDR_WIDTH - IDX_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQUEST = 2'd1;
    localparam logic [1:0] S_FETCHED = 2'd2;

    localparam logic [3:0] CU_FETCH  = 4'd1;
    localparam logic [3:0] CU_DECODE = 4'd2;

    logic [1:0]                r_state;
    logic                      r_mem_read_valid;
    logic [PC_ADDR_WIDTH-1:0]  r_mem_read_addr;
    logic [INST_MSG_WIDTH-1:0] r_instr;
    logic                      r_cache_hit;
    logic                      r_fill_cancel;

    logic [CACHE_ENTRIES-1:0]  r_valid;
    logic [TAG_W-1:0]          r_tag  [CACHE_ENTRIES];
    logic [INST_MSG_WIDTH-1:0] r_data [CACHE_ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    logic             w_fill_we;

    assign w_idx      = pc[IDX_W-1:0];
    assign w_tag      = pc[PC_ADDR_WIDTH-1:IDX_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;

    // A fill is dropped if flush is high now or was seen earlier in this request.
    assign w_fill_idx = r_mem_read_addr[IDX_W-1:0];
    assign w_fill_tag = r_mem_read_addr[PC_ADDR_WIDTH-1:IDX_W];
    assign w_fill_we  = !reset && (r_state == S_REQUEST) && mem_read_ready
                        && !flush && !r_fill_cancel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_mem_read_valid <= 1'b0;
            r_mem_read_addr  <= '0;
            r_instr          <= '0;
            r_cache_hit      <= 1'b0;
            r_fill_cancel    <= 1'b0;
            r_valid          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cache_hit <= 1'b0;
                    if (cu_state == CU_FETCH) begin
                        if (w_hit) begin
                            r_instr     <= r_data[w_idx];
                            r_cache_hit <= 1'b1;
                            r_state     <= S_FETCHED;
                        end else begin
                            r_mem_read_valid <= 1'b1;
                            r_mem_read_addr  <= pc;
                            r_fill_cancel    <= 1'b0;
                            r_state          <= S_REQUEST;
                        end
                    end
                end
                S_REQUEST: begin
                    if (flush) r_fill_cancel <= 1'b1;
                    if (mem_read_ready) begin
                        r_instr          <= mem_read_data;
                        r_mem_read_valid <= 1'b0;
                        r_state          <= S_FETCHED;
                        if (w_fill_we) r_valid[w_fill_idx] <= 1'b1;
                    end
                end
                S_FETCHED: begin
                    r_cache_hit <= 1'b0;
                    if (cu_state == CU_DECODE) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // NOTE: placed after the case so flush overrides any valid-bit set above.
            if (flush) r_valid <= '0;
        end
    end

    // NOTE: tag/data storage is not reset; the valid bits alone guard it.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_read_data;
        end
    end

    assign fetcher_state  = r_state;
    assign mem_read_valid = r_mem_read_valid;
    assign mem_read_addr  = r_mem_read_addr;
    assign instr          = r_instr;
    assign cache_hit      = r_cache_hit;

endmodule

// File: tb/tb_instr_fetcher.sv
// Directed bench for instr_fetcher: expected instructions are queued when a
// fetch is launched and compared when the fetcher reports FETCHED.
module tb_instr_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cu_state;
    logic [7:0]  pc;
    logic        flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_addr;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [1:0]  fetcher_state;
    logic [15:0] instr;
    logic        cache_hit;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    instr_fetcher #(
        .PC_ADDR_WIDTH (8),
        .INST_MSG_WIDTH(16),
        .CACHE_ENTRIES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cu_state      (cu_state),
        .pc            (pc),
        .flush         (flush),
        .mem_read_valid(mem_read_valid),
        .mem_read_addr (mem_read_addr),
        .mem_read_ready(mem_read_ready),
        .mem_read_data (mem_read_data),
        .fetcher_state (fetcher_state),
        .instr         (instr),
        .cache_hit     (cache_hit)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_instr(input string tag);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, instr);
        end else begin
            exp = exp_q.pop_front();
            check(tag, 32'(instr), 32'(exp));
        end
    endtask

    // Launch a fetch and complete it through DECODE. On a miss, memory
    // answers after 'delay' request cycles; flush pulses in request cycle
    // 'flush_at' (negative for none).
    task automatic fetch(input string tag, input logic [7:0] addr, input logic exp_hit,
                         input logic [15:0] exp_instr, input int delay, input int flush_at);
        exp_q.push_back(exp_instr);
        pc       = addr;
        cu_state = 4'd1;
        step();
        if (exp_hit) begin
            check({tag, " hit_state"}, 32'(fetcher_state), 32'd2);
            check({tag, " hit_pulse"}, 32'(cache_hit), 32'd1);
            check({tag, " hit_no_req"}, 32'(mem_read_valid), 32'd0);
            check_instr({tag, " hit_instr"});
        end else begin
            check({tag, " miss_state"}, 32'(fetcher_state), 32'd1);
            check({tag, " miss_valid"}, 32'(mem_read_valid), 32'd1);
            check({tag, " miss_addr"}, 32'(mem_read_addr), 32'(addr));
            check({tag, " miss_no_hit"}, 32'(cache_hit), 32'd0);
            pc       = addr ^ 8'hFF;
            cu_state = 4'd0;
            for (int i = 1; i < delay; i++) begin
                flush = (i == flush_at);
                step();
                flush = 1'b0;
                check({tag, " hold_valid"}, 32'(mem_read_valid), 32'd1);
                check({tag, " hold_addr"}, 32'(mem_read_addr), 32'(addr));
            end
            mem_read_ready = 1'b1;
            mem_read_data  = exp_instr;
            step();
            mem_read_ready = 1'b0;
            mem_read_data  = 16'hDEAD;
            check({tag, " resp_state"}, 32'(fetcher_state), 32'd2);
            check({tag, " resp_valid"}, 32'(mem_read_valid), 32'd0);
            check({tag, " resp_no_hit"}, 32'(cache_hit), 32'd0);
            check_instr({tag, " resp_instr"});
        end
        cu_state = 4'd2;
        step();
        check({tag, " decode_idle"}, 32'(fetcher_state), 32'd0);
        check({tag, " decode_hold"}, 32'(instr), 32'(exp_instr));
        check({tag, " pulse_end"}, 32'(cache_hit), 32'd0);
        cu_state = 4'd0;
        step();
    endtask

    initial begin
        reset          = 1'b1;
        cu_state       = 4'd1;
        pc             = 8'h10;
        flush          = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;

        // Reset held two cycles while memory strobes ready and CU asks to fetch.
        step();
        check("rst1 valid", 32'(mem_read_valid), 32'd0);
        step();
        check("rst2 valid", 32'(mem_read_valid), 32'd0);
        check("rst state", 32'(fetcher_state), 32'd0);
        check("rst addr", 32'(mem_read_addr), 32'd0);
        check("rst instr", 32'(instr), 32'd0);
        check("rst hit", 32'(cache_hit), 32'd0);
        reset          = 1'b0;
        mem_read_ready = 1'b0;
        cu_state       = 4'd0;
        step();
        check("idle state", 32'(fetcher_state), 32'd0);

        fetch("cold10", 8'h10, 1'b0, 16'h8A05, 3, -1);
        fetch("hit10", 8'h10, 1'b1, 16'h8A05, 0, -1);

        // Index 1 shared between 0x01 and 0x05.
        fetch("conf01a", 8'h01, 1'b0, 16'h1123, 1, -1);
        fetch("conf05", 8'h05, 1'b0, 16'h2456, 2, -1);
        fetch("conf01b", 8'h01, 1'b0, 16'h1123, 1, -1);
        fetch("hit10b", 8'h10, 1'b1, 16'h8A05, 0, -1);

        // Flush while idle invalidates a filled line.
        fetch("fill20", 8'h20, 1'b0, 16'h2020, 1, -1);
        fetch("hit20", 8'h20, 1'b1, 16'h2020, 0, -1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch("flushed20", 8'h20, 1'b0, 16'h2021, 2, -1);

        // Flush during a request: data delivered but not cached.
        fetch("req30", 8'h30, 1'b0, 16'h3030, 3, 1);
        fetch("miss30", 8'h30, 1'b0, 16'h3131, 1, -1);
        fetch("hit30", 8'h30, 1'b1, 16'h3131, 0, -1);

        // Reset in the middle of a request for 0x40.
        pc       = 8'h40;
        cu_state = 4'd1;
        step();
        check("mid40 valid", 32'(mem_read_valid), 32'd1);
        cu_state       = 4'd0;
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h4040;
        step();
        check("mid40 rst_valid", 32'(mem_read_valid), 32'd0);
        check("mid40 rst_state", 32'(fetcher_state), 32'd0);
        reset = 1'b0;
        step();
        check("stray ready state", 32'(fetcher_state), 32'd0);
        check("stray ready instr", 32'(instr), 32'd0);
        mem_read_ready = 1'b0;
        fetch("refetch30", 8'h30, 1'b0, 16'h3232, 1, -1);
        fetch("refetch40", 8'h40, 1'b0, 16'h4141, 2, -1);
        fetch("hit40", 8'h40, 1'b1, 16'h4141, 0, -1);

        // Top of the address space.
        fetch("missFF", 8'hFF, 1'b0, 16'hABCD, 2, -1);
        fetch("hitFF", 8'hFF, 1'b1, 16'hABCD, 0, -1);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetcher.md
Name: instr_fetcher

Overview:
Fetch stage of the compute unit. It sits directly upstream of the decoder. When the CU enters FETCH, the block looks up the current PC in a small direct-mapped instruction cache. On a miss it reads program memory over a valid/ready handshake. It then holds the 16-bit instruction stable until the CU moves to DECODE.

Parameters:
PC_ADDR_WIDTH, 8, width of PC and program-memory address
INST_MSG_WIDTH, 16, instruction width
CACHE_ENTRIES, 4, number of direct-mapped cache lines; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cu_state  in  4  CU state; FETCH=4'd1, DECODE=4'd2
pc  in  PC_ADDR_WIDTH  address to fetch; sampled in IDLE when cu_state==FETCH
flush  in  1  invalidate all cache lines
mem_read_valid  out  1  program-memory read request
mem_read_addr  out  PC_ADDR_WIDTH  request address
mem_read_ready  in  1  memory response strobe; data valid in the same cycle
mem_read_data  in  INST_MSG_WIDTH  instruction word from memory
fetcher_state  out  2  IDLE=0, REQUEST=1, FETCHED=2
instr  out  INST_MSG_WIDTH  fetched instruction, valid while fetcher_state==FETCHED
cache_hit  out  1  one-cycle pulse when a fetch is served from the cache

Behaviour:
- Clock and reset: clock clk; reset is synchronous and active-high.
- Reset values: fetcher_state=IDLE, mem_read_valid=0, mem_read_addr=0, instr=0, cache_hit=0, all valid bits=0.
- All outputs are registered.
- Cache addressing:
  - index = pc[log2(CACHE_ENTRIES)-1:0]; tag = the remaining upper PC bits.
  - Each line stores valid, tag and data.
  - hit = valid[index] && tag match && !flush.
- IDLE:
  - cache_hit<=0.
  - If cu_state==FETCH and hit: instr<=line data, cache_hit<=1, next state FETCHED. Latency is 1 cycle.
  - If cu_state==FETCH and miss: mem_read_valid<=1, mem_read_addr<=pc, next state REQUEST.
  - Any other cu_state: stay in IDLE.
- REQUEST:
  - mem_read_valid and mem_read_addr stay asserted and stable until a cycle where mem_read_ready==1.
  - In that cycle: instr<=mem_read_data, mem_read_valid<=0 at the edge, next state FETCHED.
  - In that same cycle, line[index of mem_read_addr] is written (valid=1, tag, data) unless flush is high or a flush occurred during this REQUEST.
  - pc changes while in REQUEST are ignored.
  - There is no timeout; the block waits indefinitely for mem_read_ready.
- FETCHED:
  - instr is held and cache_hit<=0.
  - When cu_state==DECODE, next state IDLE. instr keeps its value so the decoder samples it during DECODE.
- flush:
  - Clears every valid bit at the next edge, in any state.
  - Flush has priority over a fill in the same cycle.
  - A flush during REQUEST marks the outstanding fill as no-write.
  - The instruction is still delivered to instr.
- Wrap-around: PC values up to 2^PC_ADDR_WIDTH-1 index normally. No special handling is needed.
- Reset mid-REQUEST: returns to IDLE with mem_read_valid=0 and all lines invalid. A mem_read_ready arriving after reset with no request outstanding is ignored.
- mem_read_ready while not in REQUEST is ignored.
- Back-to-back fetches: after a FETCHED->IDLE return, a new fetch can start as soon as cu_state==FETCH again.

Test Plan:
- Reset: assert reset for 2 cycles with mem_read_ready=1 -> all outputs 0, fetcher_state=0, and no mem_read_valid pulse.
- Cold miss: pc=0x10, cu_state=FETCH, mem_read_ready rises 3 cycles after mem_read_valid with data 0x8A05 -> mem_read_addr=0x10 held for 3 cycles, then instr=0x8A05, fetcher_state=2, cache_hit=0. cu_state=DECODE -> IDLE next cycle.
- Hit: re-fetch pc=0x10 -> no mem_read_valid; instr=0x8A05 and cache_hit=1 one cycle after FETCH is seen.
- Conflict: fetch 0x01 (data 0x1123), then 0x05 (data 0x2456), then 0x01 again -> each of the three fetches misses (index 1 is shared), and 0x01 returns 0x1123.
- Flush: fill 0x20, pulse flush, re-fetch 0x20 -> miss. Separately, pulse flush during a REQUEST for 0x30 -> instr delivered, but the next fetch of 0x30 misses.
- Reset mid-REQUEST for 0x40 -> mem_read_valid=0 the next cycle, state IDLE. A later fetch of 0x40 issues a new request.
